// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode definitions and opcode legality check for the EXU ALU
//
// Purpose: single source of truth for the 4-bit ALU opcode map, used by the
//          core ALU datapath and by alu_arbiter when flagging illegal opcodes.
// Contents: ALU_OPT_W, ALU_* opcode localparams, is_valid_opt().
package alu_pkg;

  localparam int ALU_OPT_W = 4;

  localparam logic [ALU_OPT_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OPT_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OPT_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OPT_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OPT_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OPT_W-1:0] ALU_SR   = 4'b0101;  // SRL, or SRA when shamt = 1
  localparam logic [ALU_OPT_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OPT_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OPT_W-1:0] ALU_SUB  = 4'b1000;

  // The whole 0xxx half of the map is populated; from the 1xxx half only SUB is.
  function automatic logic is_valid_opt(input logic [ALU_OPT_W-1:0] opt);
    return (opt[3] == 1'b0) || (opt == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational integer ALU shared by both EXU requesters
//
// Purpose: computes one integer operation per cycle; undefined opcodes give 0.
// Ports:
//   src1_i  [XLEN]  operand 1
//   src2_i  [XLEN]  operand 2 (bits [4:0] are the shift amount for shifts)
//   opt_i   [4]     opcode from alu_pkg
//   shamt_i [1]     selects arithmetic right shift for ALU_SR
//   res_o   [XLEN]  result, wraps modulo 2^XLEN
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]      src1_i,
  input  logic [XLEN-1:0]      src2_i,
  input  logic [ALU_OPT_W-1:0] opt_i,
  input  logic                 shamt_i,
  output logic [XLEN-1:0]      res_o
);

  logic [4:0] sh;
  logic       lt_s;
  logic       lt_u;

  assign sh   = src2_i[4:0];
  assign lt_s = $signed(src1_i) < $signed(src2_i);
  assign lt_u = src1_i < src2_i;

  always_comb begin
    res_o = '0;
    if (is_valid_opt(opt_i)) begin
      unique case (opt_i)
        ALU_ADD:  res_o = src1_i + src2_i;
        ALU_SUB:  res_o = src1_i - src2_i;
        ALU_SLL:  res_o = src1_i << sh;
        ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, lt_s};
        ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, lt_u};
        ALU_XOR:  res_o = src1_i ^ src2_i;
        ALU_SR:   res_o = shamt_i ? XLEN'($signed(src1_i) >>> sh) : (src1_i >> sh);
        ALU_OR:   res_o = src1_i | src2_i;
        ALU_AND:  res_o = src1_i & src2_i;
        default:  res_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
//
// Purpose: grants req0 (main EXU) or req1 (AGU/branch compare) onto a single
//          alu_core and registers the result in a one-entry output slot
//          (1-cycle latency, 1 op/cycle when the consumer is always ready).
// Ports:
//   clock, i_rst_n                      clock, asynchronous active-low reset
//   reqN_valid/reqN_ready               per-requester handshake (N = 0, 1)
//   reqN_src1/src2/opt/shamt/tag        per-requester operation payload
//   rsp_valid/rsp_ready                 result slot handshake
//   rsp_res/rsp_tag/rsp_src/rsp_err     result, echoed tag, origin, illegal-opcode flag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 i_rst_n,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [XLEN-1:0]      req0_src1,
  input  logic [XLEN-1:0]      req0_src2,
  input  logic [ALU_OPT_W-1:0] req0_opt,
  input  logic                 req0_shamt,
  input  logic [TAG_W-1:0]     req0_tag,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [XLEN-1:0]      req1_src1,
  input  logic [XLEN-1:0]      req1_src2,
  input  logic [ALU_OPT_W-1:0] req1_opt,
  input  logic                 req1_shamt,
  input  logic [TAG_W-1:0]     req1_tag,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_res,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_src,
  output logic                 rsp_err
);

  logic                 last_gnt_q, last_gnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]      rsp_res_q, rsp_res_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic                 rsp_src_q, rsp_src_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 slot_free;
  logic                 gnt0, gnt1;
  logic                 accept;
  logic [XLEN-1:0]      alu_src1, alu_src2, alu_res;
  logic [ALU_OPT_W-1:0] alu_opt;
  logic                 alu_shamt;
  logic [TAG_W-1:0]     alu_tag;

  // rsp_ready reaches the request readys only through slot_free.
  assign slot_free = !rsp_valid_q || rsp_ready;

  // req1 wins when it is alone or when req0 was served last; otherwise req0
  // gets any valid request. The grants are mutually exclusive by construction.
  assign gnt1 = req1_valid && (!req0_valid || !last_gnt_q);
  assign gnt0 = req0_valid && !gnt1;

  assign req0_ready = slot_free && gnt0;
  assign req1_ready = slot_free && gnt1;
  assign accept     = req0_ready || req1_ready;

  // Operand mux follows the grant even when the slot is blocked; the result is
  // simply not captured in that case.
  assign alu_src1  = gnt1 ? req1_src1  : req0_src1;
  assign alu_src2  = gnt1 ? req1_src2  : req0_src2;
  assign alu_opt   = gnt1 ? req1_opt   : req0_opt;
  assign alu_shamt = gnt1 ? req1_shamt : req0_shamt;
  assign alu_tag   = gnt1 ? req1_tag   : req0_tag;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .src1_i  (alu_src1),
    .src2_i  (alu_src2),
    .opt_i   (alu_opt),
    .shamt_i (alu_shamt),
    .res_o   (alu_res)
  );

  always_comb begin
    last_gnt_d  = last_gnt_q;
    rsp_res_d   = rsp_res_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_src_d   = rsp_src_q;
    rsp_err_d   = rsp_err_q;
    // A drain empties the slot; data registers keep their last contents.
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    if (accept) begin
      // Covers drain-and-refill in the same cycle, so no bubble is inserted.
      rsp_valid_d = 1'b1;
      rsp_res_d   = alu_res;
      rsp_tag_d   = alu_tag;
      rsp_src_d   = gnt1;
      rsp_err_d   = !is_valid_opt(alu_opt);
      last_gnt_d  = gnt1;
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt_q  <= 1'b1;  // makes req0 the first winner under contention
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_src_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_src_q   <= rsp_src_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_src   = rsp_src_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             i_rst_n;
  logic             req0_valid, req0_ready, req0_shamt;
  logic [XLEN-1:0]  req0_src1, req0_src2;
  logic [3:0]       req0_opt;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_shamt;
  logic [XLEN-1:0]  req1_src1, req1_src2;
  logic [3:0]       req1_opt;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid, rsp_ready, rsp_src, rsp_err;
  logic [XLEN-1:0]  rsp_res;
  logic [TAG_W-1:0] rsp_tag;

  always #5 clock = ~clock;

  alu_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .i_rst_n(i_rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_opt(req0_opt), .req0_shamt(req0_shamt), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_opt(req1_opt), .req1_shamt(req1_shamt), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_err(rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: who was served last, plus the contents of the output slot.
  int               m_last;
  logic             m_valid, m_src, m_err;
  logic [XLEN-1:0]  m_res;
  logic [TAG_W-1:0] m_tag;
  int               acc_src;  // -1 when nothing was accepted in the last step

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: returns {err, result}, worked in 64-bit arithmetic.
  function automatic logic [XLEN:0] model_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [3:0] opt, input logic sh);
    longint sa, sb, ua, ub, r;
    int     n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    n  = int'(ub % 32);
    case (opt)
      4'b0000: r = ua + ub;
      4'b1000: r = ua - ub;
      4'b0001: r = ua * (longint'(1) << n);
      4'b0010: r = (sa < sb) ? 1 : 0;
      4'b0011: r = (ua < ub) ? 1 : 0;
      4'b0100: r = ua ^ ub;
      4'b0101: r = sh ? (sa >>> n) : (ua / (longint'(1) << n));
      4'b0110: r = ua | ub;
      4'b0111: r = ua & ub;
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
    return {1'b0, r[XLEN-1:0]};
  endfunction

  task automatic model_reset();
    m_last = 1; m_valid = 0; m_res = '0; m_tag = '0; m_src = 0; m_err = 0;
  endtask

  // One clock: checks outputs at the falling edge, advances the model, returns at posedge+1.
  task automatic step();
    logic g0, g1, free;
    logic [XLEN:0] r;
    @(negedge clock);
    g0   = req0_valid && (!req1_valid || m_last == 1);
    g1   = req1_valid && !g0;
    free = !m_valid || rsp_ready;
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_res",   rsp_res,   m_res);
    check("rsp_tag",   rsp_tag,   m_tag);
    check("rsp_src",   rsp_src,   m_src);
    check("rsp_err",   rsp_err,   m_err);
    check("req0_ready", req0_ready, free && g0);
    check("req1_ready", req1_ready, free && g1);
    acc_src = -1;
    if (free && (g0 || g1)) begin
      acc_src = g1 ? 1 : 0;
      r = g1 ? model_alu(req1_src1, req1_src2, req1_opt, req1_shamt)
             : model_alu(req0_src1, req0_src2, req0_opt, req0_shamt);
      m_valid = 1; m_res = r[XLEN-1:0]; m_err = r[XLEN];
      m_tag = g1 ? req1_tag : req0_tag; m_src = g1; m_last = acc_src;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] opt, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic sh, input logic [TAG_W-1:0] tg);
    req0_valid = v; req0_opt = opt; req0_src1 = a; req0_src2 = b; req0_shamt = sh; req0_tag = tg;
  endtask

  task automatic set1(input logic v, input logic [3:0] opt, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic sh, input logic [TAG_W-1:0] tg);
    req1_valid = v; req1_opt = opt; req1_src1 = a; req1_src2 = b; req1_shamt = sh; req1_tag = tg;
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rand_opt();
    logic [3:0] legal [9];
    legal = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 8)];
    return 4'($urandom());
  endfunction

  initial begin
    bit p0, p1;
    model_reset();
    i_rst_n = 1'b0;
    rsp_ready = 1'b0;
    set0(0, 4'b0000, '0, '0, 0, '0);
    set1(0, 4'b0000, '0, '0, 0, '0);
    #12;
    check("reset_valid", rsp_valid, 0);
    check("reset_res",   rsp_res,   0);
    check("reset_tag",   rsp_tag,   0);
    @(negedge clock);
    i_rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Contention: grants alternate starting with req0, results follow with no bubble.
    rsp_ready = 1'b1;
    set0(1, 4'b0000, 32'd10, 32'd1, 0, 4'd1);
    set1(1, 4'b1000, 32'd10, 32'd1, 0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_grant", acc_src, i % 2);
      check("cont_rsp_valid", rsp_valid, 1);
      check("cont_rsp_src", rsp_src, i % 2);
    end
    set0(0, 4'b0000, '0, '0, 0, '0);
    set1(0, 4'b0000, '0, '0, 0, '0);
    step();

    // Solo req0 with wrapping into the sign bit.
    set0(1, 4'b0000, 32'h7FFF_FFFF, 32'd1, 0, 4'd3);
    step();
    check("solo_accept", acc_src, 0);
    set0(0, 4'b0000, '0, '0, 0, '0);
    check("solo_valid", rsp_valid, 1);
    check("solo_res", rsp_res, 32'h8000_0000);
    check("solo_tag", rsp_tag, 3);
    check("solo_src", rsp_src, 0);
    check("solo_err", rsp_err, 0);

    // Backpressure: slot held, req1 waits, then is taken on the same cycle rsp_ready rises.
    rsp_ready = 1'b0;
    set1(1, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_no_accept", acc_src, -1);
      check("bp_res_hold", rsp_res, 32'h8000_0000);
      check("bp_tag_hold", rsp_tag, 3);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_accept", acc_src, 1);
    check("bp_new_res", rsp_res, 32'hFF00_FF00);
    check("bp_new_src", rsp_src, 1);
    set1(0, 4'b0000, '0, '0, 0, '0);

    // Shifts and compares through req0.
    set0(1, 4'b0101, 32'h8000_0000, 32'd4, 1, 4'd4); step(); check("sra", rsp_res, 32'hF800_0000);
    set0(1, 4'b0101, 32'h8000_0000, 32'd4, 0, 4'd5); step(); check("srl", rsp_res, 32'h0800_0000);
    set0(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 4'd6); step(); check("slt", rsp_res, 1);
    set0(1, 4'b0011, 32'hFFFF_FFFF, 32'd1, 0, 4'd7); step(); check("sltu", rsp_res, 0);

    // Illegal opcode still completes a normal transfer.
    set0(1, 4'b1001, 32'h1234_5678, 32'h1, 0, 4'd8);
    step();
    check("illegal_accept", acc_src, 0);
    check("illegal_res", rsp_res, 0);
    check("illegal_err", rsp_err, 1);
    set0(0, 4'b0000, '0, '0, 0, '0);

    // Asynchronous reset while the slot is full.
    check("prereset_valid", rsp_valid, 1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_err", rsp_err, 0);
    model_reset();
    @(negedge clock);
    i_rst_n = 1'b1;
    @(posedge clock);
    #1;
    set0(1, 4'b0110, 32'h1, 32'h2, 0, 4'd1);
    set1(1, 4'b0111, 32'h3, 32'h2, 0, 4'd2);
    step();
    check("post_rst_first_grant", acc_src, 0);

    // Randomised traffic; payloads are held until accepted.
    p0 = 1; p1 = 1;
    for (int c = 0; c < 400; c++) begin
      if (acc_src == 0) p0 = 0;
      if (acc_src == 1) p1 = 0;
      if (!p0 && $urandom_range(0, 2) != 0) begin
        set0(1, rand_opt(), rand_operand(), rand_operand(), 1'($urandom()), 4'($urandom()));
        p0 = 1;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        set1(1, rand_opt(), rand_operand(), rand_operand(), 1'($urandom()), 4'($urandom()));
        p1 = 1;
      end
      req0_valid = p0;
      req1_valid = p1;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
